// File: rtl/capture_pkg.sv
// Shared definitions for the frame capture path: state encoding, channel
// slicing and the ICX sensor window geometry used by the timing generator.
package capture_pkg;

  localparam int unsigned ICX_ADDR  = 12;
  localparam int unsigned ICX_WIN_W = 64;
  localparam int unsigned ICX_WIN_H = 64;
  localparam int unsigned ICX_X_OFF = 16;
  localparam int unsigned ICX_Y_OFF = 8;

  localparam int unsigned CH_W    = 16;
  localparam int unsigned CH0_LSB = 0;
  localparam int unsigned CH1_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SKIPY   = 2'd2,
    ST_CAPTURE = 2'd3
  } cap_state_e;

  // Pick one 16-bit channel out of a deserialized pixel word.
  function automatic logic [CH_W-1:0] ch_slice(input logic [2*CH_W-1:0] word,
                                               input logic            sel);
    ch_slice = sel ? word[CH1_LSB +: CH_W] : word[CH0_LSB +: CH_W];
  endfunction

endpackage

// File: rtl/frame_capture_win_counter.sv
// Position counter along one image dimension: counts steps since the last
// clear, saturates one past the window end and reports whether the current
// position lies inside the window and how far into it.
module win_counter #(
  parameter int unsigned OFF = 16,
  parameter int unsigned WIN = 64,
  parameter int unsigned CW  = $clog2(OFF + WIN + 1),
  parameter int unsigned PW  = $clog2(WIN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          step_i,
  output logic          hit_o,
  output logic [PW-1:0] pos_o,
  output logic          full_o
);

  localparam logic [CW-1:0] LO = CW'(OFF);
  localparam logic [CW-1:0] HI = CW'(OFF + WIN);

  logic [CW-1:0] cnt_q, cnt_d;

  // Advance on each step, holding at the window end so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i && (cnt_q != HI)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Window compare; pos is also the number of in-window steps seen so far.
  always_comb begin
    hit_o  = (cnt_q >= LO) && (cnt_q < HI);
    full_o = (cnt_q == HI);
    pos_o  = (cnt_q >= LO) ? PW'(cnt_q - LO) : '0;
  end

endmodule

// File: rtl/frame_capture.sv
// Armed single-shot window capture between the LVDS deserializer and BRAM
// port A. Crops WIN_W x WIN_H pixels at (X_OFF, Y_OFF) from one channel and
// writes them row-major from address 0.
module frame_capture
  import capture_pkg::*;
#(
  parameter int unsigned ADDR  = ICX_ADDR,
  parameter int unsigned WIN_W = ICX_WIN_W,
  parameter int unsigned WIN_H = ICX_WIN_H,
  parameter int unsigned X_OFF = ICX_X_OFF,
  parameter int unsigned Y_OFF = ICX_Y_OFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     pix_data,
  input  logic            pix_valid,
  input  logic            line_start,
  input  logic            frame_start,
  input  logic            ch_sel,
  input  logic            arm,
  input  logic            abort,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [15:0]     mem_din,
  output logic            busy,
  output logic            done,
  output logic            err_sync
);

  localparam int unsigned PW  = $clog2(WIN_W + 1);
  localparam int unsigned LCW = (Y_OFF > 0) ? $clog2(Y_OFF + 1) : 1;
  localparam int unsigned RW  = (WIN_H > 1) ? $clog2(WIN_H) : 1;

  localparam logic [RW-1:0]   ROW_LAST  = RW'(WIN_H - 1);
  localparam logic [PW-1:0]   COL_LAST  = PW'(WIN_W - 1);
  localparam logic [LCW-1:0]  LINE_SKIP = LCW'(Y_OFF);
  localparam logic [ADDR-1:0] ROW_STEP  = ADDR'(WIN_W);

  cap_state_e      state_q, state_d;
  logic [LCW-1:0]  line_cnt_q, line_cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [ADDR-1:0] base_q, base_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ch_q, ch_d;
  logic            mem_we_q, mem_we_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]     mem_din_q, mem_din_d;

  logic            capturing, sof, enter_cap, accept, last_px, line_end, first_pend;
  logic [LCW-1:0]  lc;
  logic            hit, full;
  logic [PW-1:0]   pos;

  win_counter #(
    .OFF (X_OFF),
    .WIN (WIN_W)
  ) u_pix (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (!capturing || abort || frame_start || line_start),
    .step_i  (capturing && pix_valid),
    .hit_o   (hit),
    .pos_o   (pos),
    .full_o  (full)
  );

  // A frame_start outside IDLE restarts line counting; a line_start in the
  // same cycle is then that frame's first line. Y_OFF lines are skipped and
  // the following line_start opens row 0.
  assign capturing  = (state_q == ST_CAPTURE);
  assign sof        = frame_start && (state_q != ST_IDLE);
  assign lc         = sof ? '0 : line_cnt_q;
  assign enter_cap  = !abort && line_start && (lc == LINE_SKIP) &&
                      (sof || (state_q == ST_SKIPY));
  assign accept     = capturing && !abort && !frame_start && !line_start &&
                      pix_valid && hit;
  assign last_px    = accept && (row_q == ROW_LAST) && (pos == COL_LAST);
  assign line_end   = capturing && !abort && !frame_start && line_start;
  assign first_pend = (row_q == '0) && (pos == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over everything.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (arm) state_d = ST_ARMED;
        ST_ARMED:   if (frame_start) state_d = enter_cap ? ST_CAPTURE : ST_SKIPY;
        ST_SKIPY:   if (enter_cap) state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          if (frame_start) begin
            state_d = enter_cap ? ST_CAPTURE : ST_SKIPY;
          end else if (last_px) begin
            state_d = ST_IDLE;
          end
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Line/row bookkeeping, sticky flags and the next BRAM write.
  always_comb begin
    line_cnt_d = line_cnt_q;
    row_d      = row_q;
    base_d     = base_q;
    done_d     = done_q;
    err_d      = err_q;
    ch_d       = ch_q;
    mem_we_d   = accept;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    if (!abort && (state_q == ST_IDLE) && arm) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      ch_d   = ch_sel;
    end

    if (!abort && (sof || (state_q == ST_SKIPY)) && line_start && !enter_cap) begin
      line_cnt_d = lc + LCW'(1);
    end else if (sof) begin
      line_cnt_d = '0;
    end

    if (capturing && frame_start && !abort) begin
      err_d = 1'b1;
    end

    if (enter_cap) begin
      row_d  = '0;
      base_d = '0;
    end

    if (line_end && !first_pend) begin
      if (!full) begin
        err_d = 1'b1;
      end
      if (row_q != ROW_LAST) begin
        row_d  = row_q + RW'(1);
        base_d = base_q + ROW_STEP;
      end
    end

    if (accept) begin
      mem_addr_d = base_q + ADDR'(pos);
      mem_din_d  = ch_slice(pix_data, ch_q);
    end

    if (last_px) begin
      done_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q <= '0;
      row_q      <= '0;
      base_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ch_q       <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
      row_q      <= row_d;
      base_q     <= base_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ch_q       <= ch_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign done     = done_q;
  assign err_sync = err_q;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: drives synthetic frames with p = line*256 + px,
// predicts every BRAM write into a queue and checks writes as they appear.
module tb_frame_capture;

  localparam int X_OFF = 16;
  localparam int Y_OFF = 8;
  localparam int WIN_W = 64;
  localparam int WIN_H = 64;
  localparam int NPIX  = 100;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic        ch_sel = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_din;
  logic        busy, done, err_sync;

  wr_t         exp_q[$];
  logic [15:0] shadow [0:4095];
  int          checks = 0;
  int          failures = 0;
  int          writes = 0;
  bit          exp_ch = 1'b0;

  frame_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .ch_sel      (ch_sel),
    .arm         (arm),
    .abort       (abort),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .busy        (busy),
    .done        (done),
    .err_sync    (err_sync)
  );

  // Free-running capture clock.
  always #5 clk = ~clk;

  // Every BRAM write must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we) begin
      writes++;
      shadow[mem_addr] = mem_din;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL write_unexpected got addr=%0d data=%h want no write", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== {e.addr, e.data}) begin
          failures++;
          $display("[TB] FAIL write_data got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr, mem_din, e.addr, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    arm = 1'b0;
    abort = 1'b0;
    line_start = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic send_line(input int line, input int npix, input int erow);
    logic [15:0] p;
    wr_t e;
    cyc();
    line_start = 1'b1;
    for (int px = 0; px < npix; px++) begin
      cyc();
      p = 16'(line * 256 + px);
      pix_valid = 1'b1;
      pix_data = {~p, p};
      if (erow >= 0 && px >= X_OFF && px < X_OFF + WIN_W) begin
        e.addr = 12'(erow * WIN_W + px - X_OFF);
        e.data = exp_ch ? ~p : p;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_lines(input int first, input int last, input bit fs,
                            input bit capture, input int short_line);
    int erow;
    if (fs) begin
      cyc();
      frame_start = 1'b1;
    end
    for (int l = first; l <= last; l++) begin
      erow = (capture && l >= Y_OFF && l < Y_OFF + WIN_H) ? l - Y_OFF : -1;
      send_line(l, (l == short_line) ? 30 : NPIX, erow);
    end
    cyc();
    cyc();
  endtask

  task automatic do_arm(input bit ch);
    cyc();
    arm = 1'b1;
    ch_sel = ch;
    exp_ch = ch;
    writes = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++; if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", err_sync); end
    checks++; if (mem_we !== 1'b0)   begin failures++; $display("[TB] FAIL reset_we got=%b want=0", mem_we); end
    checks++; if (mem_addr !== 12'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d want=0", mem_addr); end
    checks++; if (mem_din !== 16'd0) begin failures++; $display("[TB] FAIL reset_din got=%h want=0", mem_din); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_capture(input bit ch, input logic [15:0] w0, input logic [15:0] w65);
    do_arm(ch);
    send_lines(0, 79, 1'b1, 1'b1, -1);
    checks++; if (writes != 4096)     begin failures++; $display("[TB] FAIL cap%0d_writes got=%0d want=4096", ch, writes); end
    checks++; if (exp_q.size() != 0)  begin failures++; $display("[TB] FAIL cap%0d_missing got=%0d want=0", ch, exp_q.size()); end
    checks++; if (shadow[0] !== w0)   begin failures++; $display("[TB] FAIL cap%0d_addr0 got=%h want=%h", ch, shadow[0], w0); end
    checks++; if (shadow[65] !== w65) begin failures++; $display("[TB] FAIL cap%0d_addr65 got=%h want=%h", ch, shadow[65], w65); end
    checks++; if (done !== 1'b1)      begin failures++; $display("[TB] FAIL cap%0d_done got=%b want=1", ch, done); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL cap%0d_busy got=%b want=0", ch, busy); end
    checks++; if (err_sync !== 1'b0)  begin failures++; $display("[TB] FAIL cap%0d_err got=%b want=0", ch, err_sync); end
    exp_q.delete();
  endtask

  task automatic test_arm_mid_frame();
    send_lines(0, 19, 1'b1, 1'b0, -1);
    do_arm(1'b0);
    send_lines(20, 79, 1'b0, 1'b0, -1);
    checks++; if (writes != 0)     begin failures++; $display("[TB] FAIL mid_early_writes got=%0d want=0", writes); end
    checks++; if (busy !== 1'b1)   begin failures++; $display("[TB] FAIL mid_armed_busy got=%b want=1", busy); end
    send_lines(0, 79, 1'b1, 1'b1, -1);
    checks++; if (writes != 4096)  begin failures++; $display("[TB] FAIL mid_writes got=%0d want=4096", writes); end
    checks++; if (done !== 1'b1)   begin failures++; $display("[TB] FAIL mid_done got=%b want=1", done); end
    checks++; if (shadow[0] !== 16'h0810) begin failures++; $display("[TB] FAIL mid_addr0 got=%h want=0810", shadow[0]); end
    exp_q.delete();
  endtask

  task automatic test_short_line();
    do_arm(1'b0);
    send_lines(0, 79, 1'b1, 1'b1, Y_OFF + 5);
    checks++; if (err_sync !== 1'b1) begin failures++; $display("[TB] FAIL short_err got=%b want=1", err_sync); end
    checks++; if (done !== 1'b1)     begin failures++; $display("[TB] FAIL short_done got=%b want=1", done); end
    checks++; if (writes != 4046)    begin failures++; $display("[TB] FAIL short_writes got=%0d want=4046", writes); end
    checks++; if (shadow[384] !== 16'h0E10) begin failures++; $display("[TB] FAIL short_row6 got=%h want=0e10", shadow[384]); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL short_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    logic [15:0] p;
    do_arm(1'b0);
    send_lines(0, Y_OFF + 9, 1'b1, 1'b1, -1);
    send_line(Y_OFF + 10, 40, 10);
    cyc();
    p = 16'((Y_OFF + 10) * 256 + 40);
    abort = 1'b1;
    pix_valid = 1'b1;
    pix_data = {~p, p};
    cyc();
    checks++; if (busy !== 1'b0)   begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL abort_we got=%b want=0", mem_we); end
    send_lines(Y_OFF + 11, Y_OFF + 17, 1'b0, 1'b0, -1);
    checks++; if (done !== 1'b0)     begin failures++; $display("[TB] FAIL abort_done got=%b want=0", done); end
    checks++; if (writes != 664)     begin failures++; $display("[TB] FAIL abort_writes got=%0d want=664", writes); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL abort_missing got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    do_arm(1'b0);
    send_lines(0, Y_OFF + 6, 1'b1, 1'b1, -1);
    send_line(Y_OFF + 7, 50, 7);
    @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1)   begin failures++; $display("[TB] FAIL arst_pre_busy got=%b want=1", busy); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_we got=%b want=1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, err_sync, mem_we} !== 4'b0000) begin failures++; $display("[TB] FAIL arst_flags got=%b want=0000", {busy, done, err_sync, mem_we}); end
    checks++; if (mem_addr !== 12'd0) begin failures++; $display("[TB] FAIL arst_addr got=%0d want=0", mem_addr); end
    checks++; if (mem_din !== 16'd0)  begin failures++; $display("[TB] FAIL arst_din got=%h want=0", mem_din); end
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    do_arm(1'b0);
    send_lines(0, 79, 1'b1, 1'b1, -1);
    checks++; if (done !== 1'b1)    begin failures++; $display("[TB] FAIL arst_done got=%b want=1", done); end
    checks++; if (writes != 4096)   begin failures++; $display("[TB] FAIL arst_writes got=%0d want=4096", writes); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("[TB] FAIL arst_err got=%b want=0", err_sync); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_capture(1'b0, 16'h0810, 16'h0911);
    test_capture(1'b1, 16'hF7EF, 16'hF6EE);
    test_arm_mid_frame();
    test_short_line();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
